// File: rtl/spi_audio_rx_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_audio_rx_multi_if
// Brief    : Valid/ready word stream carrying a received sample and its channel tag.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_audio_rx_multi_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/spi_audio_rx_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_audio_rx_multi
// Brief    : Multi-channel SPI-style audio receiver with valid/ready output;
//            optional saturating error counter enabled by SPI_RX_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_audio_rx_multi #(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int CAPTURE_FALL = 0
) (
    input  wire logic                 clk_25mhz,
    input  wire logic                 reset,
    input  wire logic                 sclk_in,
    input  wire logic                 mosi_in,
    input  wire logic                 active,
    spi_audio_rx_multi_if.master      out_if,
    output logic                      overrun,
    output logic                      frame_err,
    output logic [7:0]                err_count
);
    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RECEIVING = 1'b1
    } state_t;

    state_t                 r_state, state_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_active_sync, r_fill;
    logic                   r_sclk_d, r_active_d, r_seen_low;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [CH_W-1:0]        r_ch_cnt;
    logic [DATA_W-2:0]      r_shift;
    logic                   r_valid;
    logic [DATA_W-1:0]      r_data;
    logic [CH_W-1:0]        r_ch;

    logic w_sclk_s, w_mosi_s, w_active_s, w_cap_edge, w_act_rise, w_act_fall;
    logic w_start, w_abort, w_shift, w_word_done, w_frame_err_set;
    logic [DATA_W-1:0] w_word;

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_active_s = r_active_sync[SYNC_STAGES-1];
    assign w_cap_edge = (CAPTURE_FALL != 0) ? (r_sclk_d & ~w_sclk_s) : (~r_sclk_d & w_sclk_s);
    // A frame may start only after active has been genuinely seen low since reset,
    // so a frame already in progress at reset release is ignored to its end.
    assign w_act_rise = r_seen_low & w_active_s & ~r_active_d;
    assign w_act_fall = ~w_active_s & r_active_d;
    assign w_word     = {r_shift, w_mosi_s};

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_sclk_sync   <= '0;
            r_mosi_sync   <= '0;
            r_active_sync <= '0;
            r_fill        <= '0;
            r_sclk_d      <= 1'b0;
            r_active_d    <= 1'b0;
            r_seen_low    <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_active_sync <= {r_active_sync[SYNC_STAGES-2:0], active};
            r_fill        <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d      <= w_sclk_s;
            r_active_d    <= w_active_s;
            if (r_fill[SYNC_STAGES-1] && !w_active_s) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= state_next;
        end
    end

    always_comb begin
        state_next      = r_state;
        w_start         = 1'b0;
        w_abort         = 1'b0;
        w_shift         = 1'b0;
        w_word_done     = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act_rise) begin
                    state_next = RECEIVING;
                    w_start    = 1'b1;
                end
            end
            RECEIVING: begin
                if (w_act_fall) begin
                    state_next      = IDLE;
                    w_abort         = 1'b1;
                    w_frame_err_set = (r_bit_cnt != '0) || (r_ch_cnt != '0);
                end else if (w_cap_edge) begin
                    w_shift     = 1'b1;
                    w_word_done = (r_bit_cnt == BIT_LAST);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ch      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= w_frame_err_set;
            if (w_start || w_abort) begin
                r_bit_cnt <= '0;
                r_ch_cnt  <= '0;
                r_shift   <= '0;
            end else if (w_shift) begin
                r_shift <= w_word[DATA_W-2:0];
                if (w_word_done) begin
                    r_bit_cnt <= '0;
                    r_ch_cnt  <= (r_ch_cnt == CH_LAST) ? '0 : r_ch_cnt + 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            // A completed word replaces the held one only if the slot is free this cycle.
            if (w_word_done) begin
                if (!r_valid || out_if.out_ready) begin
                    r_valid <= 1'b1;
                    r_data  <= w_word;
                    r_ch    <= r_ch_cnt;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (r_valid && out_if.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_ch    = r_ch;

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if ((overrun || frame_err) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_audio_rx_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_audio_rx_multi
// Brief    : Self-checking bench for spi_audio_rx_multi (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_audio_rx_multi;
    localparam int DW = 16;
    localparam int NC = 2;
`ifdef SPI_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
        logic        exp_ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_in = 1'b0;
    logic       mosi_in = 1'b0;
    logic       active = 1'b0;
    logic       overrun, frame_err;
    logic [7:0] err_count;

    spi_audio_rx_multi_if #(.DATA_W(DW), .NUM_CH(NC)) out_if ();

    spi_audio_rx_multi #(
        .DATA_W(DW), .NUM_CH(NC), .SYNC_STAGES(2), .CAPTURE_FALL(0)
    ) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .mosi_in   (mosi_in),
        .active    (active),
        .out_if    (out_if.master),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int half = 3;
    int n_ovr = 0, n_ferr = 0, n_vrise = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event counters sampled just after each active edge
    always begin
        @(posedge clk);
        #1;
        if (overrun === 1'b1) n_ovr++;
        if (frame_err === 1'b1) n_ferr++;
        if (out_if.out_valid === 1'b1 && prev_v !== 1'b1) n_vrise++;
        prev_v = out_if.out_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic send_bits(input logic [31:0] w, input int nbits, input bit chk,
                             input logic [15:0] exp_d, input logic exp_ch, input string tag);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk);
            sclk_in = 1'b0;
            mosi_in = w[i];
            repeat (half) @(negedge clk);
            sclk_in = 1'b1;
            if (chk && i == 0) begin
                @(posedge clk);
                @(posedge clk); #1;
                check({tag, " early valid"}, {31'd0, out_if.out_valid}, 32'd0);
                @(posedge clk); #1;
                check({tag, " valid"}, {31'd0, out_if.out_valid}, 32'd1);
                check({tag, " data"}, {16'd0, out_if.out_data}, {16'd0, exp_d});
                check({tag, " ch"}, {31'd0, out_if.out_ch}, {31'd0, exp_ch});
                check({tag, " overrun"}, {31'd0, overrun}, 32'd0);
            end else begin
                repeat (half - 1) @(negedge clk);
            end
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        sclk_in = 1'b0;
        active  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        active = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    vec_t vecs[4];
    int   base_ovr, base_ferr, base_vr;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b0};
        vecs[1] = '{16'h1234, 16'h1234, 1'b1};
        vecs[2] = '{16'hBEEF, 16'hBEEF, 1'b0};
        vecs[3] = '{16'h0F0F, 16'h0F0F, 1'b1};
        out_if.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst valid", {31'd0, out_if.out_valid}, 32'd0);
        check("rst data", {16'd0, out_if.out_data}, 32'd0);
        check("rst ch", {31'd0, out_if.out_ch}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        check("rst frame_err", {31'd0, frame_err}, 32'd0);
        check("rst err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Streaming with ready high, channel wrap and latency
        out_if.out_ready = 1'b1;
        start_frame();
        for (int k = 0; k < 4; k++) begin
            send_bits({16'd0, vecs[k].word}, 16, 1'b1, vecs[k].exp_data, vecs[k].exp_ch,
                      $sformatf("vec%0d", k));
        end
        end_frame();
        check("stream overruns", n_ovr, 0);
        check("stream frame_err", n_ferr, 0);

        // Backpressure: second word overruns and is dropped
        out_if.out_ready = 1'b0;
        start_frame();
        send_bits(32'h0000AAAA, 16, 1'b0, 16'h0, 1'b0, "bp0");
        send_bits(32'h00005555, 16, 1'b0, 16'h0, 1'b0, "bp1");
        repeat (3) @(negedge clk);
        check("bp valid", {31'd0, out_if.out_valid}, 32'd1);
        check("bp data held", {16'd0, out_if.out_data}, 32'h0000AAAA);
        check("bp ch held", {31'd0, out_if.out_ch}, 32'd0);
        check("bp overrun count", n_ovr, 1);
        end_frame();
        check("bp err_count", {24'd0, err_count}, ERR_EN ? 32'd1 : 32'd0);
        out_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp drained", {31'd0, out_if.out_valid}, 32'd0);

        // Frame aborted after 7 bits
        base_vr = n_vrise;
        start_frame();
        send_bits(32'h0000007F, 7, 1'b0, 16'h0, 1'b0, "partial");
        end_frame();
        check("abort frame_err", n_ferr, 1);
        check("abort no word", n_vrise, base_vr);
        start_frame();
        send_bits(32'h0000C0DE, 16, 1'b1, 16'hC0DE, 1'b0, "after abort w0");
        send_bits(32'h00007E57, 16, 1'b1, 16'h7E57, 1'b1, "after abort w1");
        end_frame();
        check("after abort frame_err", n_ferr, 1);

        // Reset mid-word with a held word
        out_if.out_ready = 1'b0;
        start_frame();
        send_bits(32'h00001111, 16, 1'b0, 16'h0, 1'b0, "pre-rst");
        send_bits(32'h00000015, 5, 1'b0, 16'h0, 1'b0, "pre-rst part");
        check("pre-rst valid", {31'd0, out_if.out_valid}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst valid", {31'd0, out_if.out_valid}, 32'd0);
        check("midrst data", {16'd0, out_if.out_data}, 32'd0);
        check("midrst ch", {31'd0, out_if.out_ch}, 32'd0);
        check("midrst err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base_vr   = n_vrise;
        base_ferr = n_ferr;
        send_bits(32'h05A5A5A5, 27, 1'b0, 16'h0, 1'b0, "post-rst");
        repeat (4) @(negedge clk);
        check("post-rst no word", n_vrise, base_vr);
        check("post-rst valid", {31'd0, out_if.out_valid}, 32'd0);
        end_frame();
        check("post-rst frame_err", n_ferr, base_ferr);
        out_if.out_ready = 1'b1;
        start_frame();
        send_bits(32'h00002222, 16, 1'b1, 16'h2222, 1'b0, "restart w0");
        send_bits(32'h00003333, 16, 1'b1, 16'h3333, 1'b1, "restart w1");
        end_frame();

        // Error counter saturation under a long overrun burst
        half = 2;
        out_if.out_ready = 1'b0;
        base_ovr = n_ovr;
        start_frame();
        for (int k = 0; k < 101; k++) begin
            send_bits(32'h00009000 + k, 16, 1'b0, 16'h0, 1'b0, "burst");
        end
        repeat (3) @(negedge clk);
        check("burst ovr 100", n_ovr - base_ovr, 100);
        check("err_count 100", {24'd0, err_count}, ERR_EN ? 32'd100 : 32'd0);
        for (int k = 0; k < 201; k++) begin
            send_bits(32'h00004000 + k, 16, 1'b0, 16'h0, 1'b0, "burst");
        end
        repeat (3) @(negedge clk);
        check("burst ovr 301", n_ovr - base_ovr, 301);
        check("err_count sat", {24'd0, err_count}, ERR_EN ? 32'd255 : 32'd0);
        check("burst data held", {16'd0, out_if.out_data}, 32'h00009000);
        end_frame();
        out_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("burst drained", {31'd0, out_if.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_audio_rx_multi.md
# spi_audio_rx_multi

Parametrised serial audio receiver: second-generation Pico→FPGA link. Captures SPI-style serial data (sclk_in/mosi_in, framed by active) into DATA_W-bit words across NUM_CH interleaved channels. Presents each word with its channel tag on a valid/ready output, and flags overruns and malformed frames. Sits between the Pico link pins and the audio processing path, all in the clk_25mhz domain.

## Interface
- DATA_W, 16: bits per sample word (4..32)
- NUM_CH, 2: interleaved channels per frame (1..8)
- SYNC_STAGES, 2: synchroniser depth for sclk_in, mosi_in and active (2..4)
- CAPTURE_FALL, 0: 0 = capture mosi on sclk rising edge; 1 = capture on falling edge
- clk_25mhz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sclk_in  in  1  serial clock from Pico (asynchronous)
- mosi_in  in  1  serial data, MSB first (asynchronous)
- active  in  1  frame enable from Pico, high while streaming (asynchronous)
- out_valid  out  1  out_data/out_ch hold a word
- out_ready  in  1  downstream accepts word when out_valid & out_ready
- out_data  out  DATA_W  received sample
- out_ch  out  CH_W  channel index of out_data; CH_W = max(1, $clog2(NUM_CH))
- overrun  out  1  one-cycle pulse: completed word dropped
- frame_err  out  1  one-cycle pulse: active fell mid-frame
- err_count  out  8  saturating error counter (see Configuration)

## Operation
- sclk_in, mosi_in, active each pass through SYNC_STAGES flops. One history flop on synchronised sclk and active. Capture edge = synchronised sclk transition selected by CAPTURE_FALL.
- States: IDLE, RECEIVING.
- IDLE: on synchronised active rising → RECEIVING. bit_cnt=0, ch_cnt=0, shift register cleared.
- RECEIVING: each capture edge shifts synchronised mosi into the shift register LSB (MSB-first stream) and increments bit_cnt.
- When bit_cnt == DATA_W-1 and a capture edge occurs, the word is complete: the full word including this bit is offered to the output register with tag ch_cnt. bit_cnt → 0. ch_cnt increments, wrapping NUM_CH-1 → 0.
- Output register load: allowed if out_valid==0 or out_ready==1 in the same cycle; new word and tag loaded, out_valid=1. Otherwise the new word is dropped, the held word is kept unchanged, and overrun pulses.
- out_valid clears on out_valid & out_ready with no simultaneous load.
- Synchronised active falling in RECEIVING → IDLE. If bit_cnt≠0 or ch_cnt≠0, frame_err pulses and the partial word is discarded. Words already completed are never discarded.
- Active falling and capture edge in the same cycle: active falling wins; the edge is ignored.
- Capture edges in IDLE are ignored.
- The output handshake keeps operating in IDLE, so a held word drains normally.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, overrun=0, frame_err=0, err_count=0. State IDLE, counters 0, sync chains 0.
- Reset mid-frame: held word lost. The receiver restarts only on a fresh active rising edge seen after reset deassertion.
- Latency: out_valid rises at the SYNC_STAGES-th clk_25mhz edge after the edge that first samples the final capture-level sclk_in.
- out_data and out_ch stable while out_valid=1 and out_ready=0.
- Throughput: one word accepted per cycle when out_ready held high.
- sclk_in high and low phases each ≥ 2 clk_25mhz periods, i.e. sclk_in ≤ 6.25 MHz. mosi_in stable ≥ 1 period around the capture edge.
- active setup to first capture edge ≥ 2 periods.

## Configuration
- SPI_RX_ERR_CNT_EN defined: err_count increments by 1 on each overrun or frame_err pulse and saturates at 255. If both pulse in the same cycle, it increments by 1 only. Cleared only by reset.
- Not defined: err_count tied to 8'd0; counter logic absent; overrun and frame_err pulses are unaffected.

## Test plan
- Default params, active high, send 0xA5C3 then 0x1234, out_ready=1 → two words: out_data=0xA5C3 with out_ch=0, then 0x1234 with out_ch=1. No error pulses.
- NUM_CH=2, send 4 words → out_ch sequence 0,1,0,1 (wrap). out_valid latency = SYNC_STAGES cycles after the last sclk edge of each word is sampled.
- out_ready=0, send 2 words → first word held; overrun pulses once on completion of the second word; out_data stays at the first word. Then out_ready=1 → first word accepted, out_valid falls.
- Drop active after 7 bits of a word → frame_err single pulse; no out_valid. The next frame's first word is received intact with out_ch=0.
- Assert reset mid-word with out_valid=1 → all outputs 0 next cycle. The remaining bits of the interrupted frame produce no word until active toggles low→high.
- SPI_RX_ERR_CNT_EN defined, generate 300 overruns → err_count saturates at 255. Macro undefined → err_count stays 0.
